spi_frame_responder: RTL and testbench

SPI_FRAME_RESPONDER -- requirements
Module: spi_frame_responder

---
 rtl/spi_frame_responder.sv | 151 +++++++++++++++
 tb/tb_spi_frame_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_responder.sv
// SPI mode-0 target that streams frame memory (cmd 0x03 + 16-bit address) or an ID byte (cmd 0x9F).
// All SPI inputs are 2-flop synchronised into CLK_40; SCK edges are detected on the synchronised value.
module spi_frame_responder #(
  parameter int          ADDR_W  = 16,
  parameter logic [7:0]  ID_BYTE = 8'hBA
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              SPI_clk,
  input  logic              chip_select,
  input  logic              MOSI,
  output logic              MISO,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR_HI = 3'd2;
  localparam logic [2:0] S_ADDR_LO = 3'd3;
  localparam logic [2:0] S_STREAM  = 3'd4;
  localparam logic [2:0] S_ID_OUT  = 3'd5;
  localparam logic [2:0] S_IGNORE  = 3'd6;

  logic [1:0]        r_sck_s, r_cs_s, r_mosi_s;
  logic              r_sck_d, r_cs_d;
  logic [2:0]        r_state;
  logic [2:0]        r_bitcnt;
  logic [6:0]        r_shift_in;
  logic [14:0]       r_addr_sr;
  logic [7:0]        r_shift_out;
  logic [ADDR_W-1:0] r_addr;
  logic              r_miso, r_mem_rd, r_load, r_cmd_err;

  logic              w_sck_rise, w_sck_fall, w_cs_fall, w_cs_edge, w_mosi;
  logic [7:0]        w_byte;
  logic [15:0]       w_addr16;

  assign w_sck_rise = r_sck_s[1] & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s[1] & r_sck_d;
  assign w_cs_fall  = ~r_cs_s[1] & r_cs_d;
  assign w_cs_edge  = r_cs_s[1] ^ r_cs_d;
  assign w_mosi     = r_mosi_s[1];
  assign w_byte     = {r_shift_in, w_mosi};
  assign w_addr16   = {r_addr_sr, w_mosi};

  // CS synchronisers reset to "selected" so a select held across reset is not seen as a fresh edge.
  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      r_sck_s     <= '0;
      r_cs_s      <= '0;
      r_mosi_s    <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b0;
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shift_in  <= '0;
      r_addr_sr   <= '0;
      r_shift_out <= '0;
      r_addr      <= '0;
      r_miso      <= 1'b1;
      r_mem_rd    <= 1'b0;
      r_load      <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[0], SPI_clk};
      r_cs_s   <= {r_cs_s[0], chip_select};
      r_mosi_s <= {r_mosi_s[0], MOSI};
      r_sck_d  <= r_sck_s[1];
      r_cs_d   <= r_cs_s[1];
      r_mem_rd <= 1'b0;
      r_load   <= r_mem_rd;
      // Read data is valid the cycle after mem_rd, so capture one cycle after r_load is set.
      if (r_load && r_state == S_STREAM)
        r_shift_out <= mem_rdata;

      if (r_state == S_IDLE) begin
        r_miso <= 1'b1;
        if (w_cs_fall) begin
          r_state    <= S_CMD;
          r_bitcnt   <= '0;
          r_shift_in <= '0;
        end
      end else if (r_cs_s[1]) begin
        r_state  <= S_IDLE;
        r_miso   <= 1'b1;
        r_bitcnt <= '0;
        r_load   <= 1'b0;
      end else if (!w_cs_edge && w_sck_rise) begin
        case (r_state)
          S_CMD: begin
            r_shift_in <= w_byte[6:0];
            r_bitcnt   <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (w_byte == 8'h03) begin
                r_state <= S_ADDR_HI;
              end else if (w_byte == 8'h9F) begin
                r_state     <= S_ID_OUT;
                r_shift_out <= ID_BYTE;
              end else begin
                r_state   <= S_IGNORE;
                r_cmd_err <= 1'b1;
              end
            end
          end
          S_ADDR_HI: begin
            r_addr_sr <= w_addr16[14:0];
            r_bitcnt  <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7)
              r_state <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            r_addr_sr <= w_addr16[14:0];
            r_bitcnt  <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state  <= S_STREAM;
              r_addr   <= ADDR_W'(w_addr16);
              r_mem_rd <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (!w_cs_edge && w_sck_fall) begin
        if (r_state == S_STREAM || r_state == S_ID_OUT) begin
          r_miso      <= r_shift_out[7];
          r_shift_out <= {r_shift_out[6:0], 1'b0};
          r_bitcnt    <= r_bitcnt + 3'd1;
          // Bit 0 is going out: prefetch the next byte well before its bit-7 edge.
          if (r_bitcnt == 3'd7) begin
            if (r_state == S_STREAM) begin
              r_addr   <= r_addr + 1'b1;
              r_mem_rd <= 1'b1;
            end else begin
              r_shift_out <= ID_BYTE;
            end
          end
        end
      end
    end
  end

  assign MISO     = r_miso;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_addr;
  assign busy     = (r_state != S_IDLE);
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_frame_responder.sv
// Directed bench: SPI initiator driving reads, identify, bad command, aborts and reset.
module tb_spi_frame_responder;

  logic        CLK_40 = 1'b0;
  logic        reset;
  logic        SPI_clk;
  logic        chip_select;
  logic        MOSI;
  logic        MISO;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        cmd_err;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  rx;

  spi_frame_responder #(.ADDR_W(16), .ID_BYTE(8'hBA)) dut (
    .CLK_40(CLK_40), .reset(reset), .SPI_clk(SPI_clk), .chip_select(chip_select),
    .MOSI(MOSI), .MISO(MISO), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 CLK_40 = ~CLK_40;

  always @(posedge CLK_40) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_q.push_back(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // MISO is captured just before each rising edge, as a mode-0 initiator would.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = tx[i];
      #80;
      r[i] = MISO;
      SPI_clk = 1'b1;
      #80;
      SPI_clk = 1'b0;
    end
  endtask

  task automatic select();
    chip_select = 1'b0;
    #80;
  endtask

  task automatic deselect();
    #80;
    chip_select = 1'b1;
    #100;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'hA5;
    mem[16'h0101] = 8'h3C;
    mem[16'hFFFF] = 8'h81;
    mem[16'h0000] = 8'h7E;
    mem_rdata   = 8'h00;
    reset       = 1'b1;
    SPI_clk     = 1'b0;
    chip_select = 1'b1;
    MOSI        = 1'b0;
    #1;
    check("rst_miso", MISO, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_cmd_err", cmd_err, 0);
    repeat (2) @(posedge CLK_40);
    #1 reset = 1'b0;
    #100;

    // Streaming read from 0x0100
    rd_q.delete();
    select();
    check("sel_busy", busy, 1);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("rd_byte0", rx, 8'hA5);
    spi_xfer(8'hFF, 8, rx);
    check("rd_byte1", rx, 8'h3C);
    deselect();
    check("rd_count", rd_q.size(), 3);
    check("rd_addr0", rd_q[0], 16'h0100);
    check("rd_addr1", rd_q[1], 16'h0101);
    check("rd_busy_off", busy, 0);

    // Address wrap
    rd_q.delete();
    select();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'hFF, 8, rx);
    spi_xfer(8'hFF, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("wrap_byte0", rx, 8'h81);
    spi_xfer(8'h00, 8, rx);
    check("wrap_byte1", rx, 8'h7E);
    deselect();
    check("wrap_addr0", rd_q[0], 16'hFFFF);
    check("wrap_addr1", rd_q[1], 16'h0000);

    // Identify
    select();
    spi_xfer(8'h9F, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("id_byte0", rx, 8'hBA);
    spi_xfer(8'hFF, 8, rx);
    check("id_byte1", rx, 8'hBA);
    check("id_cmd_err", cmd_err, 0);
    deselect();

    // Unknown command
    select();
    spi_xfer(8'h55, 8, rx);
    check("bad_cmd_err", cmd_err, 1);
    spi_xfer(8'h03, 8, rx);
    check("bad_miso", rx, 8'hFF);
    deselect();
    check("bad_err_sticky", cmd_err, 1);
    check("bad_busy_off", busy, 0);

    // Abort after 4 data bits, then reselect
    rd_q.delete();
    select();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h00, 4, rx);
    #80;
    check("abort_busy_on", busy, 1);
    @(posedge CLK_40);
    #1 chip_select = 1'b1;
    repeat (3) @(posedge CLK_40);
    #1;
    check("abort_busy_3cyc", busy, 0);
    check("abort_miso", MISO, 1);
    #100;
    check("abort_no_rd", rd_q.size(), 1);
    select();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("resel_byte", rx, 8'h3C);
    check("resel_addr", rd_q[1], 16'h0101);
    deselect();

    // Reset mid-stream, then clocks with select still held low
    select();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h00, 3, rx);
    #23 reset = 1'b1;
    #1;
    check("mid_rst_miso", MISO, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_rd", mem_rd, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_cmd_err", cmd_err, 0);
    #56 reset = 1'b0;
    rd_q.delete();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("post_rst_miso", rx, 8'hFF);
    spi_xfer(8'h00, 8, rx);
    check("post_rst_no_rd", rd_q.size(), 0);
    check("post_rst_busy", busy, 0);
    chip_select = 1'b1;
    #100;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
